// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: forwarding-select encodings, hazard FSM states
// and the default register-index width.
package riscv_pipe_pkg;

    localparam int unsigned REG_ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_e;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Hazard-unit bundle: pipeline-stage register indices and controls in,
// forwarding selects, stall/flush enables and perf counters out.
interface hazard_control_unit_if #(
    parameter int unsigned REG_ADDR_W = riscv_pipe_pkg::REG_ADDR_W_DEF,
    parameter int unsigned CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] RS1_D;
    logic [REG_ADDR_W-1:0] RS2_D;
    logic [REG_ADDR_W-1:0] RS1_E;
    logic [REG_ADDR_W-1:0] RS2_E;
    logic [REG_ADDR_W-1:0] RD_E;
    logic [REG_ADDR_W-1:0] RD_M;
    logic [REG_ADDR_W-1:0] RD_W;
    logic                  RegWriteM;
    logic                  RegWriteW;
    logic                  LoadE;
    logic                  PCSrcE;
    logic                  MultiCycleE;
    logic                  perf_clr;

    logic [1:0]            ForwardAE;
    logic [1:0]            ForwardBE;
    logic                  StallF;
    logic                  StallD;
    logic                  StallE;
    logic                  FlushD;
    logic                  FlushE;
    logic                  FlushM;
    logic                  mc_busy;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        output RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W,
               RegWriteM, RegWriteW, LoadE, PCSrcE, MultiCycleE, perf_clr,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE,
               FlushD, FlushE, FlushM, mc_busy, stall_cnt, flush_cnt
    );

    modport slave (
        input  RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W,
               RegWriteM, RegWriteW, LoadE, PCSrcE, MultiCycleE, perf_clr,
        output ForwardAE, ForwardBE, StallF, StallD, StallE,
               FlushD, FlushE, FlushM, mc_busy, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_perf_counter.sv
// Saturating event counter with synchronous clear (clear beats increment).
module hazard_perf_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush,
// multi-cycle execute stall FSM and stall/flush performance counters.
module hazard_control_unit
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int unsigned MC_LATENCY = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    hazard_control_unit_if.slave  hz
);
    localparam bit          MC_MULTI = (MC_LATENCY > 1);
    localparam int unsigned MC_CNT_W = (MC_LATENCY > 2) ? $clog2(MC_LATENCY - 1) : 1;
    localparam int unsigned MC_LOAD_I = (MC_LATENCY > 2) ? (MC_LATENCY - 2) : 0;
    localparam logic [MC_CNT_W-1:0] MC_LOAD = MC_CNT_W'(MC_LOAD_I);

    mc_state_e             state_q, state_d;
    logic [MC_CNT_W-1:0]   count_q, count_d;
    logic                  mc_enter;
    logic                  mc_stall;
    logic                  lw_stall;
    logic                  br_flush;
    logic                  stall_fd;
    logic                  flush_e;
    fwd_sel_e              fwd_a, fwd_b;

    // Memory stage wins over Writeback; x0 never forwards.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (hz.RegWriteM && (hz.RD_M != '0) && (hz.RD_M == hz.RS1_E)) begin
            fwd_a = FWD_MEM;
        end else if (hz.RegWriteW && (hz.RD_W != '0) && (hz.RD_W == hz.RS1_E)) begin
            fwd_a = FWD_WB;
        end
        if (hz.RegWriteM && (hz.RD_M != '0) && (hz.RD_M == hz.RS2_E)) begin
            fwd_b = FWD_MEM;
        end else if (hz.RegWriteW && (hz.RD_W != '0) && (hz.RD_W == hz.RS2_E)) begin
            fwd_b = FWD_WB;
        end
    end

    // Multi-cycle FSM: count holds the remaining BUSY cycles after this one.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mc_enter = 1'b0;
        case (state_q)
            MC_IDLE: begin
                if (hz.MultiCycleE && MC_MULTI) begin
                    state_d  = MC_BUSY;
                    count_d  = MC_LOAD;
                    mc_enter = 1'b1;
                end
            end
            MC_BUSY: begin
                if (count_q == '0) begin
                    state_d = MC_IDLE;
                end else begin
                    count_d = count_q - MC_CNT_W'(1);
                end
            end
            default: state_d = MC_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MC_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Priority: multi-cycle stall, then branch flush, then load-use.
    always_comb begin
        mc_stall = mc_enter || ((state_q == MC_BUSY) && (count_q != '0));
        lw_stall = hz.LoadE && (hz.RD_E != '0) &&
                   ((hz.RD_E == hz.RS1_D) || (hz.RD_E == hz.RS2_D));
        br_flush = hz.PCSrcE && !mc_stall;
        stall_fd = mc_stall || (lw_stall && !br_flush);
        flush_e  = br_flush || (lw_stall && !mc_stall);
    end

    hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (hz.perf_clr),
        .inc (stall_fd),
        .cnt (hz.stall_cnt)
    );

    hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .clr (hz.perf_clr),
        .inc (br_flush),
        .cnt (hz.flush_cnt)
    );

    // Stall/flush enables are held low for as long as reset is asserted.
    assign hz.ForwardAE = fwd_a;
    assign hz.ForwardBE = fwd_b;
    assign hz.StallF    = stall_fd && !rst;
    assign hz.StallD    = stall_fd && !rst;
    assign hz.StallE    = mc_stall && !rst;
    assign hz.FlushM    = mc_stall && !rst;
    assign hz.FlushD    = br_flush && !rst;
    assign hz.FlushE    = flush_e && !rst;
    assign hz.mc_busy   = (state_q == MC_BUSY);
endmodule
